lsu_ctrl: RTL and testbench

- Load/store sequencer between the execute stage and a handshaked data-memory bus.
- Accepts one load or store at a time and checks alignment.
- Issues a word-aligned bus transaction with byte strobes and waits for the response, with a timeout.
- Extracts and extends load data, then presents a one-cycle register-writeback or exception pulse. Used in place of a single-cycle memory path when memory latency is variable.

---
 rtl/lsu_ctrl.sv | 231 +++++++++++++++++++++++
 tb/tb_lsu_ctrl.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/lsu_ctrl.sv
// Load/store sequencer: checks alignment, runs one handshaked bus transaction with
// byte strobes and a response timeout, then pulses writeback/done or an exception.
//
// state  | meaning
// IDLE   | ready for a request; illegal/misaligned requests are rejected here
// REQ    | bus_valid asserted, waiting for bus_ready
// RESP   | waiting for bus_rvalid, timeout counter running
// DONE   | one-cycle completion pulse (and load writeback)
module lsu_ctrl #(
    parameter int CPU_WIDTH = 32,
    parameter int TIMEOUT   = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 req_valid,
    output logic                 req_ready,
    input  logic                 req_we,
    input  logic [2:0]           req_funct3,
    input  logic [CPU_WIDTH-1:0] req_addr,
    input  logic [CPU_WIDTH-1:0] req_wdata,
    input  logic [4:0]           req_rd,
    output logic                 bus_valid,
    input  logic                 bus_ready,
    output logic                 bus_we,
    output logic [CPU_WIDTH-1:0] bus_addr,
    output logic [CPU_WIDTH-1:0] bus_wdata,
    output logic [3:0]           bus_wstrb,
    input  logic                 bus_rvalid,
    input  logic [CPU_WIDTH-1:0] bus_rdata,
    input  logic                 bus_err,
    output logic                 wb_valid,
    output logic [4:0]           wb_rd,
    output logic [CPU_WIDTH-1:0] wb_data,
    output logic                 done,
    output logic                 exc,
    output logic [1:0]           exc_cause,
    output logic                 busy
);

    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_REQ  = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] TO_LAST = CW'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

    logic [1:0]           state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic                 we_q, we_d;
    logic [2:0]           f3_q, f3_d;
    logic [1:0]           lo_q, lo_d;
    logic [4:0]           rd_q, rd_d;
    logic [CPU_WIDTH-1:0] baddr_q, baddr_d;
    logic [CPU_WIDTH-1:0] bwdata_q, bwdata_d;
    logic [3:0]           bwstrb_q, bwstrb_d;
    logic [CPU_WIDTH-1:0] wb_data_q, wb_data_d;
    logic [4:0]           wb_rd_q, wb_rd_d;
    logic                 exc_q, exc_d;
    logic [1:0]           cause_q, cause_d;

    logic                 illegal, misaligned;
    logic [CPU_WIDTH-1:0] fmt_wdata;
    logic [3:0]           fmt_wstrb;
    logic [7:0]           ld_byte;
    logic [15:0]          ld_half;
    logic [CPU_WIDTH-1:0] ld_data;

    always_comb begin
        illegal = (req_funct3 == 3'd3) || (req_funct3[2:1] == 2'b11)
                  || (req_we && (req_funct3[2:1] == 2'b10));
        case (req_funct3)
            3'd1, 3'd5: misaligned = req_addr[0];
            3'd2:       misaligned = (req_addr[1:0] != 2'b00);
            default:    misaligned = 1'b0;
        endcase
    end

    // Store data is replicated across lanes so the strobes alone select the target bytes.
    always_comb begin
        fmt_wdata = '0;
        fmt_wstrb = 4'b0000;
        if (req_we) begin
            case (req_funct3[1:0])
                2'd0: begin
                    fmt_wdata = {4{req_wdata[7:0]}};
                    fmt_wstrb = 4'b0001 << req_addr[1:0];
                end
                2'd1: begin
                    fmt_wdata = {2{req_wdata[15:0]}};
                    fmt_wstrb = req_addr[1] ? 4'b1100 : 4'b0011;
                end
                default: begin
                    fmt_wdata = req_wdata;
                    fmt_wstrb = 4'b1111;
                end
            endcase
        end
    end

    always_comb begin
        case (lo_q)
            2'd0:    ld_byte = bus_rdata[7:0];
            2'd1:    ld_byte = bus_rdata[15:8];
            2'd2:    ld_byte = bus_rdata[23:16];
            default: ld_byte = bus_rdata[31:24];
        endcase
        ld_half = lo_q[1] ? bus_rdata[31:16] : bus_rdata[15:0];
        case (f3_q)
            3'd0:    ld_data = {{24{ld_byte[7]}}, ld_byte};
            3'd1:    ld_data = {{16{ld_half[15]}}, ld_half};
            3'd4:    ld_data = {24'd0, ld_byte};
            3'd5:    ld_data = {16'd0, ld_half};
            default: ld_data = bus_rdata;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        we_d      = we_q;
        f3_d      = f3_q;
        lo_d      = lo_q;
        rd_d      = rd_q;
        baddr_d   = baddr_q;
        bwdata_d  = bwdata_q;
        bwstrb_d  = bwstrb_q;
        wb_data_d = wb_data_q;
        wb_rd_d   = wb_rd_q;
        exc_d     = 1'b0;
        cause_d   = cause_q;
        case (state_q)
            S_IDLE: begin
                if (req_valid) begin
                    if (illegal) begin
                        exc_d   = 1'b1;
                        cause_d = 2'd0;
                    end else if (misaligned) begin
                        exc_d   = 1'b1;
                        cause_d = 2'd1;
                    end else begin
                        we_d     = req_we;
                        f3_d     = req_funct3;
                        lo_d     = req_addr[1:0];
                        rd_d     = req_rd;
                        baddr_d  = {req_addr[CPU_WIDTH-1:2], 2'b00};
                        bwdata_d = fmt_wdata;
                        bwstrb_d = fmt_wstrb;
                        state_d  = S_REQ;
                    end
                end
            end
            S_REQ: begin
                if (bus_ready) begin
                    cnt_d   = '0;
                    state_d = S_RESP;
                end
            end
            S_RESP: begin
                // A response in the last allowed cycle takes priority over the timeout.
                if (bus_rvalid) begin
                    if (bus_err) begin
                        exc_d   = 1'b1;
                        cause_d = 2'd2;
                        state_d = S_IDLE;
                    end else begin
                        if (!we_q) begin
                            wb_data_d = ld_data;
                            wb_rd_d   = rd_q;
                        end
                        state_d = S_DONE;
                    end
                end else if ((TIMEOUT != 0) && (cnt_q == TO_LAST)) begin
                    exc_d   = 1'b1;
                    cause_d = 2'd3;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q   <= S_IDLE;
            cnt_q     <= '0;
            we_q      <= 1'b0;
            f3_q      <= 3'd0;
            lo_q      <= 2'd0;
            rd_q      <= 5'd0;
            baddr_q   <= '0;
            bwdata_q  <= '0;
            bwstrb_q  <= 4'b0000;
            wb_data_q <= '0;
            wb_rd_q   <= 5'd0;
            exc_q     <= 1'b0;
            cause_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            we_q      <= we_d;
            f3_q      <= f3_d;
            lo_q      <= lo_d;
            rd_q      <= rd_d;
            baddr_q   <= baddr_d;
            bwdata_q  <= bwdata_d;
            bwstrb_q  <= bwstrb_d;
            wb_data_q <= wb_data_d;
            wb_rd_q   <= wb_rd_d;
            exc_q     <= exc_d;
            cause_q   <= cause_d;
        end
    end

    assign req_ready = (state_q == S_IDLE);
    assign busy      = (state_q != S_IDLE);
    assign bus_valid = (state_q == S_REQ);
    assign bus_we    = we_q;
    assign bus_addr  = baddr_q;
    assign bus_wdata = bwdata_q;
    assign bus_wstrb = bwstrb_q;
    assign done      = (state_q == S_DONE);
    assign wb_valid  = (state_q == S_DONE) && !we_q;
    assign wb_rd     = wb_rd_q;
    assign wb_data   = wb_data_q;
    assign exc       = exc_q;
    assign exc_cause = cause_q;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Randomized scoreboard bench for lsu_ctrl: the driver pushes expected outcomes from a
// plain-arithmetic reference model; a monitor pops and compares on every done/exc pulse.
module tb_lsu_ctrl;
    localparam int TIMEOUT = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        bus_valid, bus_ready, bus_we;
    logic [31:0] bus_addr, bus_wdata;
    logic [3:0]  bus_wstrb;
    logic        bus_rvalid, bus_err;
    logic [31:0] bus_rdata;
    logic        wb_valid;
    logic [4:0]  wb_rd;
    logic [31:0] wb_data;
    logic        done, exc, busy;
    logic [1:0]  exc_cause;

    always #5 clk = ~clk;

    lsu_ctrl #(.CPU_WIDTH(32), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .bus_valid(bus_valid), .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
        .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .bus_err(bus_err),
        .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
        .done(done), .exc(exc), .exc_cause(exc_cause), .busy(busy)
    );

    typedef struct {
        bit        is_exc;
        bit [1:0]  cause;
        bit        wbv;
        bit [4:0]  rd;
        bit [31:0] data;
        int        cyc;
    } exp_t;

    exp_t sb_q[$];
    int tests = 0, fails = 0, pushed = 0, popped = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(string name, logic [31:0] act, logic [31:0] expv);
        tests++;
        if (act !== expv) begin
            fails++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, act, expv, cyc);
        end
    endtask

    function automatic int size_of(bit [2:0] f3);
        case (f3[1:0])
            2'd0:    return 1;
            2'd1:    return 2;
            default: return 4;
        endcase
    endfunction

    // Reference: classify, then derive outcome, data and pulse cycle from the bus timing.
    function automatic exp_t model(bit we, bit [2:0] f3, bit [31:0] addr, bit [4:0] rd,
                                   int rdly, int k, bit err, bit [31:0] rdata, int acc,
                                   output bit go_bus);
        exp_t e;
        int sz, off, lat;
        bit [31:0] sh, v;
        bit illegal;
        sz  = size_of(f3);
        off = int'(addr % 4);
        illegal = (f3 inside {3'd3, 3'd6, 3'd7}) || (we && (f3 inside {3'd4, 3'd5}));
        e.is_exc = 1'b0; e.cause = 2'd0; e.wbv = 1'b0; e.rd = rd; e.data = 32'd0;
        go_bus = 1'b0;
        if (illegal) begin
            e.is_exc = 1'b1; e.cause = 2'd0; lat = 1;
        end else if ((addr % sz) != 0) begin
            e.is_exc = 1'b1; e.cause = 2'd1; lat = 1;
        end else begin
            go_bus = 1'b1;
            if (k > TIMEOUT) begin
                e.is_exc = 1'b1; e.cause = 2'd3; lat = 2 + rdly + TIMEOUT;
            end else if (err) begin
                e.is_exc = 1'b1; e.cause = 2'd2; lat = 2 + rdly + k;
            end else begin
                lat = 2 + rdly + k;
                e.wbv = !we;
                sh = rdata >> (8 * off);
                if (sz == 1) begin
                    v = sh & 32'hFF;
                    if (f3 < 4 && v >= 128) v = v - 256;
                end else if (sz == 2) begin
                    v = sh & 32'hFFFF;
                    if (f3 < 4 && v >= 32768) v = v - 65536;
                end else begin
                    v = rdata;
                end
                e.data = v;
            end
        end
        e.cyc = acc + lat - 1;
        return e;
    endfunction

    always @(negedge clk) begin
        exp_t e;
        if (rst_n === 1'b1 && (done === 1'b1 || exc === 1'b1)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {30'd0, done, exc}, 32'd0);
            end else begin
                e = sb_q.pop_front();
                popped++;
                chk("pulse_kind", {30'd0, exc, done}, e.is_exc ? 32'd2 : 32'd1);
                if (e.is_exc) chk("exc_cause", 32'(exc_cause), 32'(e.cause));
                chk("wb_valid", 32'(wb_valid), 32'(e.wbv));
                if (e.wbv) begin
                    chk("wb_rd", 32'(wb_rd), 32'(e.rd));
                    chk("wb_data", wb_data, e.data);
                end
                chk("pulse_cycle", 32'(cyc), 32'(e.cyc));
            end
        end else if (rst_n === 1'b1 && wb_valid === 1'b1) begin
            chk("stray_wb_valid", 32'(wb_valid), 32'd0);
        end
    end

    task automatic do_txn(bit we, bit [2:0] f3, bit [31:0] addr, bit [31:0] wdata, bit [4:0] rd,
                          int rdly, int k, bit err, bit [31:0] rdata);
        exp_t e;
        bit go;
        int sz, off, n;
        bit [31:0] ewd;
        bit [3:0]  est;
        sz  = size_of(f3);
        off = int'(addr % 4);
        ewd = (sz == 1) ? (wdata & 32'hFF) * 32'h01010101 :
              (sz == 2) ? (wdata & 32'hFFFF) * 32'h00010001 : wdata;
        est = we ? 4'(((1 << sz) - 1) << off) : 4'd0;
        @(negedge clk);
        chk("req_ready_idle", 32'(req_ready), 32'd1);
        e = model(we, f3, addr, rd, rdly, k, err, rdata, cyc + 1, go);
        sb_q.push_back(e);
        pushed++;
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr;
        req_wdata = wdata; req_rd = rd;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = $urandom;
        req_wdata = $urandom;
        if (!go) begin
            chk("no_bus_valid", 32'(bus_valid), 32'd0);
        end else begin
            for (int i = 0; i <= rdly; i++) begin
                chk("bus_valid", 32'(bus_valid), 32'd1);
                chk("bus_we", 32'(bus_we), 32'(we));
                chk("bus_addr", bus_addr, addr & ~32'd3);
                chk("bus_wstrb", 32'(bus_wstrb), 32'(est));
                if (we) chk("bus_wdata", bus_wdata, ewd);
                if (i == rdly) bus_ready = 1'b1;
                @(negedge clk);
            end
            bus_ready = 1'b0;
            if (k <= TIMEOUT) begin
                repeat (k - 1) @(negedge clk);
                bus_rvalid = 1'b1; bus_err = err; bus_rdata = rdata;
                @(negedge clk);
                bus_rvalid = 1'b0; bus_err = 1'b0; bus_rdata = $urandom;
            end
        end
        n = 0;
        while (popped != pushed && n < 64) begin
            @(negedge clk);
            n++;
        end
        if (popped != pushed) begin
            chk("response_timeout", 32'(popped), 32'(pushed));
            sb_q.delete();
            popped = pushed;
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit we, err;
        bit [2:0] f3;
        bit [31:0] addr;
        int sz, rdly, k;

        rst_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'd0;
        req_addr = 32'd0; req_wdata = 32'd0; req_rd = 5'd0;
        bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = 32'd0; bus_err = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_bus_valid", 32'(bus_valid), 32'd0);
        chk("rst_bus_we", 32'(bus_we), 32'd0);
        chk("rst_bus_addr", bus_addr, 32'd0);
        chk("rst_bus_wdata", bus_wdata, 32'd0);
        chk("rst_bus_wstrb", 32'(bus_wstrb), 32'd0);
        chk("rst_pulses", {29'd0, done, exc, wb_valid}, 32'd0);
        chk("rst_wb_data", wb_data, 32'd0);
        chk("rst_wb_rd", 32'(wb_rd), 32'd0);
        chk("rst_exc_cause", 32'(exc_cause), 32'd0);
        rst_n = 1'b1;

        do_txn(1'b0, 3'd0, 32'h103, 32'h0, 5'd7, 0, 1, 1'b0, 32'h80AA55CC);
        do_txn(1'b0, 3'd4, 32'h103, 32'h0, 5'd8, 0, 1, 1'b0, 32'h80AA55CC);
        do_txn(1'b1, 3'd1, 32'h202, 32'h1234ABCD, 5'd0, 4, 1, 1'b0, 32'h0);
        do_txn(1'b0, 3'd2, 32'h301, 32'h0, 5'd3, 0, 1, 1'b0, 32'h0);
        do_txn(1'b1, 3'd4, 32'h300, 32'h55, 5'd0, 0, 1, 1'b0, 32'h0);
        do_txn(1'b0, 3'd1, 32'h10, 32'h0, 5'd9, 0, TIMEOUT + 1, 1'b0, 32'h0000F00D);
        do_txn(1'b0, 3'd1, 32'h10, 32'h0, 5'd9, 0, TIMEOUT, 1'b0, 32'h0000F00D);
        do_txn(1'b0, 3'd2, 32'h40, 32'h0, 5'd4, 1, 2, 1'b1, 32'hDEADBEEF);
        do_txn(1'b0, 3'd2, 32'h44, 32'h0, 5'd4, 0, 1, 1'b0, 32'hCAFEF00D);
        do_txn(1'b0, 3'd5, 32'h46, 32'h0, 5'd31, 2, 3, 1'b0, 32'h9ABC1234);

        // Reset while waiting for a response: no pulse, and a late response is ignored.
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'd2; req_addr = 32'h80; req_rd = 5'd5;
        @(negedge clk);
        req_valid = 1'b0;
        bus_ready = 1'b1;
        @(negedge clk);
        bus_ready = 1'b0;
        @(negedge clk);
        chk("pre_reset_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        chk("midrst_bus_valid", 32'(bus_valid), 32'd0);
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_pulses", {29'd0, done, exc, wb_valid}, 32'd0);
        rst_n = 1'b1;
        bus_rvalid = 1'b1; bus_rdata = 32'h11111111;
        @(negedge clk);
        bus_rvalid = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("late_rvalid_pulses", {29'd0, done, exc, wb_valid}, 32'd0);
            @(negedge clk);
        end
        do_txn(1'b1, 3'd0, 32'h87, 32'h000000A5, 5'd0, 0, 1, 1'b0, 32'h0);

        for (int t = 0; t < 150; t++) begin
            we   = 1'($urandom % 2);
            f3   = 3'($urandom % 8);
            addr = $urandom;
            sz   = size_of(f3);
            if ($urandom % 4 != 0) addr = addr & ~32'(sz - 1);
            rdly = int'($urandom % 4);
            k    = ($urandom % 10 < 7) ? 1 + int'($urandom % 4) : 14 + int'($urandom % 5);
            err  = ($urandom % 8 == 0);
            do_txn(we, f3, addr, $urandom, 5'($urandom), rdly, k, err, $urandom);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
